// File: rtl/riscv_v_pkg.sv
// ============================================================================
// riscv_v_pkg : shared vector types for the WB/forwarding producer pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_v_pkg;

  localparam int RISCV_V_NUM_BYTES_DATA = 16;
  localparam int RISCV_V_VL_WIDTH       = $clog2(RISCV_V_NUM_BYTES_DATA) + 1;

  typedef logic [4:0]                            riscv_instr_rd_t;
  typedef logic [8*RISCV_V_NUM_BYTES_DATA-1:0]   riscv_v_data_t;
  typedef logic [3:0]                            osize_vector_t;
  typedef logic [RISCV_V_NUM_BYTES_DATA-1:0]     riscv_v_mask_t;
  typedef logic [RISCV_V_NUM_BYTES_DATA-1:0]     riscv_v_rf_wr_en_t;
  typedef logic [RISCV_V_VL_WIDTH-1:0]           riscv_v_vl_t;

  typedef struct packed {
    logic              valid;
    riscv_v_rf_wr_en_t en;
    riscv_instr_rd_t   addr;
    riscv_v_data_t     data;
    logic              osize_err;
  } riscv_v_wb_stage_t;

  function automatic logic riscv_v_osize_onehot(input osize_vector_t osize);
    return (osize != '0) && ((osize & (osize - 4'd1)) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_v_wb_byte_en.sv
// ============================================================================
// riscv_v_wb_byte_en : per-byte RF write enables from element size, vl, v0 mask
// Optional: RISCV_V_MASK_AGNOSTIC_EN enables all-ones fill of masked-off bytes
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_v_wb_byte_en
  import riscv_v_pkg::*;
#(
  parameter int NUM_BYTES = RISCV_V_NUM_BYTES_DATA,
  parameter int VL_WIDTH  = $clog2(RISCV_V_NUM_BYTES_DATA) + 1
) (
  input  logic                valid,
  input  logic                wr_en,
  input  osize_vector_t       osize,
  input  logic                masked,
  input  riscv_v_mask_t       mask,
  input  logic [VL_WIDTH-1:0] vl,
  input  riscv_v_data_t       data_in,
  output riscv_v_rf_wr_en_t   be,
  output riscv_v_data_t       data_out,
  output logic                osize_err
);

  localparam int IDX_W = $clog2(NUM_BYTES);

  logic [1:0] w_shift;
  logic       w_onehot;
  logic       w_gate;

  always_comb begin
    w_shift = '0;
    for (int k = 0; k < 4; k++) begin
      if (osize[k]) w_shift = 2'(k);
    end
  end

  assign w_onehot  = riscv_v_osize_onehot(osize);
  assign w_gate    = valid & wr_en & w_onehot;
  assign osize_err = ~w_onehot;

  for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
    logic [IDX_W-1:0] w_elem;
    logic             w_active;
    logic             w_live;

    assign w_elem   = IDX_W'(b) >> w_shift;
    assign w_active = VL_WIDTH'(w_elem) < vl;
    assign w_live   = w_active & (~masked | mask[w_elem]);
`ifdef RISCV_V_MASK_AGNOSTIC_EN
    // Masked-off active bytes are written with ones; tail bytes stay untouched.
    assign be[b]             = w_gate & w_active;
    assign data_out[8*b +: 8] = (w_active & ~w_live) ? 8'hFF : data_in[8*b +: 8];
`else
    assign be[b]             = w_gate & w_live;
    assign data_out[8*b +: 8] = data_in[8*b +: 8];
`endif
  end

endmodule

`default_nettype wire

// File: rtl/riscv_v_wb_pipe.sv
// ============================================================================
// riscv_v_wb_pipe : EXE->MEM->WB producer registers for vector forwarding
// Optional: RISCV_V_MASK_AGNOSTIC_EN (via riscv_v_wb_byte_en). Rev 1.0
// ============================================================================
`default_nettype none

module riscv_v_wb_pipe
  import riscv_v_pkg::*;
#(
  parameter int NUM_BYTES = RISCV_V_NUM_BYTES_DATA,
  parameter int VL_WIDTH  = $clog2(RISCV_V_NUM_BYTES_DATA) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exe_valid,
  input  logic                exe_wr_en,
  input  riscv_instr_rd_t     exe_rd,
  input  riscv_v_data_t       exe_data,
  input  osize_vector_t       exe_osize,
  input  logic                exe_masked,
  input  riscv_v_mask_t       exe_mask,
  input  logic [VL_WIDTH-1:0] exe_vl,
  input  logic                stall,
  input  logic                flush,
  output riscv_v_rf_wr_en_t   rf_wr_en_mem,
  output riscv_instr_rd_t     rf_wr_addr_mem,
  output riscv_v_data_t       rf_wr_data_mem,
  output riscv_v_rf_wr_en_t   rf_wr_en_wb,
  output riscv_instr_rd_t     rf_wr_addr_wb,
  output riscv_v_data_t       rf_wr_data_wb,
  output logic                wb_retire,
  output logic                osize_err
);

  riscv_v_rf_wr_en_t w_be;
  riscv_v_data_t     w_data;
  logic              w_osize_bad;
  riscv_v_wb_stage_t w_mem_next;
  riscv_v_wb_stage_t r_mem;

  logic              r_wb_valid;
  riscv_v_rf_wr_en_t r_wb_en;
  riscv_instr_rd_t   r_wb_addr;
  riscv_v_data_t     r_wb_data;

  riscv_v_wb_byte_en #(
    .NUM_BYTES (NUM_BYTES),
    .VL_WIDTH  (VL_WIDTH)
  ) u_byte_en (
    .valid     (exe_valid),
    .wr_en     (exe_wr_en),
    .osize     (exe_osize),
    .masked    (exe_masked),
    .mask      (exe_mask),
    .vl        (exe_vl),
    .data_in   (exe_data),
    .be        (w_be),
    .data_out  (w_data),
    .osize_err (w_osize_bad)
  );

  // A flushed instruction still lands addr/data in MEM but as an invalid bubble.
  always_comb begin
    w_mem_next      = '0;
    w_mem_next.addr = exe_rd;
    w_mem_next.data = w_data;
    if (!flush) begin
      w_mem_next.valid     = exe_valid;
      w_mem_next.en        = w_be;
      w_mem_next.osize_err = exe_valid & w_osize_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_en    <= '0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (!stall) begin
      r_mem      <= w_mem_next;
      r_wb_valid <= r_mem.valid;
      r_wb_en    <= r_mem.en;
      r_wb_addr  <= r_mem.addr;
      r_wb_data  <= r_mem.data;
    end
  end

  assign rf_wr_en_mem   = r_mem.en;
  assign rf_wr_addr_mem = r_mem.addr;
  assign rf_wr_data_mem = r_mem.data;
  assign osize_err      = r_mem.osize_err;
  assign rf_wr_en_wb    = r_wb_en;
  assign rf_wr_addr_wb  = r_wb_addr;
  assign rf_wr_data_wb  = r_wb_data;
  // WB content leaves on every unstalled cycle, so this fires exactly once per instruction.
  assign wb_retire      = r_wb_valid & ~stall;

endmodule

`default_nettype wire
